ram_param_clr: RTL and testbench
================================

// Module: ram_param_clr
// PURPOSE
//  Parametrised single-port RAM, successor to the fixed 8x16 register-file RAM.
//  Width and depth are generic, with a selectable registered read port.
//  A built-in clear engine zeroes every word after reset or on request.
//  Used as general data/scratch memory in the Hack-style datapath.
// PARAMETERS
//  WIDTH     16  data word width in bits (>=1)
//  ADDR_W    3   address width; DEPTH = 2**ADDR_W words (localparam, >=1)
//  READ_REG  1   1: registered read, 1-cycle latency; 0: combinational read
// PORTS
//  clk    input   1        rising-edge clock
//  rst_n  input   1        asynchronous active-low reset
//  in     input   WIDTH    write data
//  addr   input   ADDR_W   read/write address
//  write  input   1        write enable, sampled on rising clk
//  clear  input   1        start a clear sweep; 1-cycle pulse or level
//  out    output  WIDTH    read data
//  busy   output  1        clear sweep in progress; writes are ignored
// BEHAVIOUR
//  - FSM states: CLEAR, IDLE. rst_n=0 forces CLEAR immediately (async):
//    clr_ptr=0, busy=1, out=0 (registered out cleared; comb out forced 0).
//  - Memory array has no async reset; contents are defined only after a sweep.
//  - CLEAR: each rising edge writes 0 to mem[clr_ptr], clr_ptr++.
//    The edge that writes word DEPTH-1 moves the FSM to IDLE and drops busy.
//    After rst_n rises, busy stays high for exactly DEPTH clock edges.
//  - IDLE: clear=1 on an edge moves to CLEAR with clr_ptr=0 and busy=1;
//    the sweep starts on the next edge. Any write on that edge still occurs.
//  - clear during CLEAR is ignored; it does not restart or extend the sweep.
//  - rst_n asserted mid-sweep aborts the sweep. The sweep restarts at address 0.
//  - Write: in IDLE with write=1, mem[addr] <= in on the rising edge.
//    write=1 while busy=1 is dropped silently and is not queued.
//  - Read with READ_REG=1: out <= mem[addr] on every edge, so latency is 1 cycle.
//    On a same-edge write to the same addr, out gets the new data (write-first).
//  - Read with READ_REG=0: out = mem[addr] combinationally.
//    A write becomes visible after the edge.
//  - Reads while busy: out = 0 in both modes.
//  - addr is full-range; no out-of-range case exists. clr_ptr wraps only via FSM exit.
// TESTING
//  1. Reset release, defaults -> busy=1 for exactly 8 edges, then 0.
//     Reading addr 0..7 then gives out=0x0000 for each.
//  2. IDLE, write=1 addr=5 in=0xBEEF, then read addr=5
//     -> out=0xBEEF one edge later (READ_REG=1).
//  3. Write addr=2 in=0x1234 while busy=1 -> after sweep, read addr 2 = 0x0000.
//  4. Same-edge write addr=3 in=0xA5A5 with addr=3 read, READ_REG=1
//     -> out=0xA5A5 after that edge.
//  5. Fill all words with 0xFFFF, pulse clear for 1 cycle -> busy=1 for 8 edges.
//     Then all reads give 0. rst_n low mid-sweep -> out=0 immediately;
//     sweep restarts and takes 8 edges.
//  6. WIDTH=8, ADDR_W=4, READ_REG=0: write 0x3C to addr 15
//     -> out=0x3C combinationally after the edge; sweep lasts 16 edges.

Source files
------------

// File: rtl/ram_param_clr_if.sv
// Bus bundle for ram_param_clr: write/read port, clear request and status.
interface ram_param_clr_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
);
  logic [WIDTH-1:0]  in;
  logic [ADDR_W-1:0] addr;
  logic              write;
  logic              clear;
  logic [WIDTH-1:0]  out;
  logic              busy;

  modport master (
    output in,
    output addr,
    output write,
    output clear,
    input  out,
    input  busy
  );

  modport slave (
    input  in,
    input  addr,
    input  write,
    input  clear,
    output out,
    output busy
  );
endinterface

// File: rtl/ram_param_clr.sv
// Parametrised single-port RAM with a built-in clear sweep that zeroes every
// word after reset or on request. Optional registered (write-first) read port.
module ram_param_clr #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          READ_REG = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  ram_param_clr_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StClear, StIdle} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  // Next state and the single memory write port (sweep or user write).
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = bus.addr;
    mem_wdata = bus.in;
    case (state_q)
      StClear: begin
        // User writes and clear requests are dropped while sweeping.
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        // A write on the same edge as a clear request still lands.
        mem_we = bus.write;
        if (bus.clear) begin
          state_d   = StClear;
          clr_ptr_d = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // Control state; reset aborts any sweep and restarts it from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Storage array; no reset, contents defined only once a sweep completes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.busy = (state_q == StClear);

  if (READ_REG) begin : g_rd_reg
    logic [WIDTH-1:0] out_q, out_d;

    // Write-first read; held at zero whenever the next state is sweeping.
    always_comb begin
      out_d = mem_q[bus.addr];
      if (mem_we && (mem_waddr == bus.addr)) begin
        out_d = mem_wdata;
      end
      if (state_d == StClear) begin
        out_d = '0;
      end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
      end else begin
        out_q <= out_d;
      end
    end

    assign bus.out = out_q;
  end else begin : g_rd_comb
    assign bus.out = bus.busy ? '0 : mem_q[bus.addr];
  end

endmodule

// File: tb/tb_ram_param_clr.sv
// Directed self-checking bench: default RAM (16x8, registered read) and a
// 8-bit x16 combinational-read variant sharing clock and reset.
module tb_ram_param_clr;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ram_param_clr_if #(.WIDTH(16), .ADDR_W(3)) bus_a ();
  ram_param_clr_if #(.WIDTH(8),  .ADDR_W(4)) bus_b ();

  ram_param_clr #(.WIDTH(16), .ADDR_W(3), .READ_REG(1'b1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  ram_param_clr #(.WIDTH(8), .ADDR_W(4), .READ_REG(1'b0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until each DUT drops busy (0 if it never does within bound).
  task automatic sweep_len(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (na == 0 && !bus_a.busy) na = k;
      if (nb == 0 && !bus_b.busy) nb = k;
      if (na != 0 && nb != 0) break;
    end
  endtask

  task automatic fill_a(input logic [15:0] val);
    for (int i = 0; i < 8; i++) begin
      bus_a.addr  = 3'(i);
      bus_a.in    = val;
      bus_a.write = 1'b1;
      step();
    end
    bus_a.write = 1'b0;
  endtask

  task automatic read_all_a(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 8; i++) begin
      bus_a.addr = 3'(i);
      step();
      check($sformatf("%s_a%0d", tag, i), 32'(bus_a.out), 32'(exp));
    end
  endtask

  int na, nb;

  initial begin
    bus_a.in = '0; bus_a.addr = '0; bus_a.write = 1'b0; bus_a.clear = 1'b0;
    bus_b.in = '0; bus_b.addr = '0; bus_b.write = 1'b0; bus_b.clear = 1'b0;

    // Reset state.
    #2;
    check("rst_busy_a", 32'(bus_a.busy), 32'd1);
    check("rst_out_a",  32'(bus_a.out),  32'd0);
    check("rst_busy_b", 32'(bus_b.busy), 32'd1);
    check("rst_out_b",  32'(bus_b.out),  32'd0);
    step();
    step();
    check("rst_hold_busy_a", 32'(bus_a.busy), 32'd1);

    // Reset release: sweep of DEPTH edges.
    rst_n = 1'b1;
    #1;
    check("rel_busy_a", 32'(bus_a.busy), 32'd1);
    sweep_len(na, nb);
    check("sweep_len_a", 32'(na), 32'd8);
    check("sweep_len_b", 32'(nb), 32'd16);
    read_all_a("init", 16'h0000);

    // Combinational-read variant.
    bus_b.addr  = 4'd15;
    bus_b.in    = 8'h3C;
    bus_b.write = 1'b1;
    #1;
    check("b_pre_edge", 32'(bus_b.out), 32'h00);
    step();
    bus_b.write = 1'b0;
    #1;
    check("b_after_edge", 32'(bus_b.out), 32'h3C);
    bus_b.addr = 4'd14;
    #1;
    check("b_comb_a14", 32'(bus_b.out), 32'h00);
    bus_b.addr = 4'd15;
    #1;
    check("b_comb_a15", 32'(bus_b.out), 32'h3C);

    // Write then read, one-edge latency.
    bus_a.addr  = 3'd5;
    bus_a.in    = 16'hBEEF;
    bus_a.write = 1'b1;
    step();
    bus_a.write = 1'b0;
    bus_a.addr  = 3'd0;
    step();
    check("rd_a0", 32'(bus_a.out), 32'h0000);
    bus_a.addr = 3'd5;
    step();
    check("rd_a5", 32'(bus_a.out), 32'hBEEF);

    // Same-edge write and read of one address is write-first.
    bus_a.addr  = 3'd3;
    bus_a.in    = 16'hA5A5;
    bus_a.write = 1'b1;
    step();
    bus_a.write = 1'b0;
    check("wr_first_a3", 32'(bus_a.out), 32'hA5A5);

    // Fill, pulse clear; writes and clears during sweep are ignored.
    fill_a(16'hFFFF);
    bus_a.addr = 3'd7;
    step();
    check("fill_a7", 32'(bus_a.out), 32'hFFFF);
    bus_a.clear = 1'b1;
    step();
    bus_a.clear = 1'b0;
    check("clr_busy", 32'(bus_a.busy), 32'd1);
    check("clr_out0", 32'(bus_a.out),  32'h0000);
    na = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 3) begin
        bus_a.addr  = 3'd2;
        bus_a.in    = 16'h1234;
        bus_a.write = 1'b1;
      end else begin
        bus_a.write = 1'b0;
      end
      bus_a.clear = (k == 2);
      step();
      if (!bus_a.busy) begin
        na = k;
        break;
      end
    end
    bus_a.write = 1'b0;
    bus_a.clear = 1'b0;
    check("clr_sweep_len", 32'(na), 32'd8);
    read_all_a("clr", 16'h0000);

    // Reset mid-sweep aborts and restarts from word 0.
    fill_a(16'hFFFF);
    bus_a.addr  = 3'd1;
    bus_a.clear = 1'b1;
    step();
    bus_a.clear = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_out",  32'(bus_a.out),  32'h0000);
    check("midrst_busy", 32'(bus_a.busy), 32'd1);
    #3;
    rst_n = 1'b1;
    sweep_len(na, nb);
    check("rerst_len_a", 32'(na), 32'd8);
    check("rerst_len_b", 32'(nb), 32'd16);
    read_all_a("rerst", 16'h0000);
    bus_b.addr = 4'd15;
    #1;
    check("rerst_b15", 32'(bus_b.out), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
